led_path_player: RTL and testbench

Animated LED driver for the BST mini-game. It takes a node index from the switch decoder and plays the root-to-node search path on LEDR1..LEDR7, one node per step. It then holds the full path and signals completion. If the request is invalid, it blinks LEDR8/LEDR9 as an error indication instead. It sits between the switch decoder and the board LED pins, under control of the game FSM.

---
 rtl/led_path_player.sv | 184 ++++++++++++++++++
 tb/tb_led_path_player.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/led_path_player.sv
// led_path_player: plays the root-to-node BST search path on LEDR1..LEDR7,
// then holds the full path; invalid requests blink LEDR8/LEDR9 instead.
module led_path_player #(
  parameter int unsigned STEP_CYCLES = 25_000_000,
  parameter int unsigned ERR_BLINKS  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] target,
  input  logic       target_ok,
  output logic [9:0] ledr,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int unsigned BW = $clog2(ERR_BLINKS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(STEP_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(ERR_BLINKS);
  localparam logic [9:0]    LED_ERR   = 10'h300;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WALK    = 3'd1,
    S_HOLD    = 3'd2,
    S_ERR_ON  = 3'd3,
    S_ERR_OFF = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [2:0]    r_target, w_target_nxt;
  logic [1:0]    r_depth, w_depth_nxt;
  logic [1:0]    r_step, w_step_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [BW-1:0] r_blink, w_blink_nxt;
  logic [6:0]    r_mask, w_mask_nxt;
  logic [9:0]    w_ledr_nxt;
  logic          w_busy_nxt, w_done_nxt, w_error_nxt;
  logic          w_cnt_end;
  logic [2:0]    w_anc;

  // Depth of a heap-ordered node in the 7-node tree.
  function automatic logic [1:0] node_depth(input logic [2:0] n);
    if (n == 3'd0)      return 2'd0;
    else if (n <= 3'd2) return 2'd1;
    else                return 2'd2;
  endfunction

  // Walk 'up' parent steps from node n.
  function automatic logic [2:0] ancestor(input logic [2:0] n, input logic [1:0] up);
    logic [2:0] a;
    a = n;
    for (int i = 0; i < 2; i++) begin
      if (2'(i) < up) a = (a - 3'd1) >> 1;
    end
    return a;
  endfunction

  // One-hot LED for node n (node i drives ledr[i+1]).
  function automatic logic [9:0] node_led(input logic [2:0] n);
    return 10'd2 << n;
  endfunction

  assign w_cnt_end = (r_cnt == CNT_MAX);

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_depth  <= '0;
      r_step   <= '0;
      r_cnt    <= '0;
      r_blink  <= '0;
      r_mask   <= '0;
      ledr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_target <= w_target_nxt;
      r_depth  <= w_depth_nxt;
      r_step   <= w_step_nxt;
      r_cnt    <= w_cnt_nxt;
      r_blink  <= w_blink_nxt;
      r_mask   <= w_mask_nxt;
      ledr     <= w_ledr_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
      error    <= w_error_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_target_nxt = r_target;
    w_depth_nxt  = r_depth;
    w_step_nxt   = r_step;
    w_cnt_nxt    = r_cnt + CW'(1);
    w_blink_nxt  = r_blink;
    w_mask_nxt   = r_mask;
    w_ledr_nxt   = ledr;
    w_busy_nxt   = busy;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;
    w_anc        = 3'd0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt  = '0;
        w_ledr_nxt = '0;
        w_busy_nxt = 1'b0;
        if (start) begin
          w_busy_nxt = 1'b1;
          if (target_ok && (target != 3'd7)) begin
            w_state_nxt  = S_WALK;
            w_target_nxt = target;
            w_depth_nxt  = node_depth(target);
            w_step_nxt   = 2'd0;
            w_mask_nxt   = 7'd1;
            w_ledr_nxt   = node_led(3'd0);
          end else begin
            w_state_nxt = S_ERR_ON;
            w_blink_nxt = '0;
            w_ledr_nxt  = LED_ERR;
          end
        end
      end
      S_WALK: begin
        if (w_cnt_end) begin
          w_cnt_nxt = '0;
          if (r_step == r_depth) begin
            w_state_nxt = S_HOLD;
            w_ledr_nxt  = {2'b00, r_mask, 1'b0};
          end else begin
            w_step_nxt = r_step + 2'd1;
            w_anc      = ancestor(r_target, r_depth - w_step_nxt);
            w_mask_nxt = r_mask | 7'(7'd1 << w_anc);
            w_ledr_nxt = node_led(w_anc);
          end
        end
      end
      S_HOLD: begin
        if (w_cnt_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_mask_nxt  = '0;
          w_ledr_nxt  = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_ERR_ON: begin
        if (w_cnt_end) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_ERR_OFF;
          w_ledr_nxt  = '0;
        end
      end
      S_ERR_OFF: begin
        if (w_cnt_end) begin
          w_cnt_nxt   = '0;
          w_blink_nxt = BW'(r_blink + 1'b1);
          if (w_blink_nxt == BLINK_MAX) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_error_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ERR_ON;
            w_ledr_nxt  = LED_ERR;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_led_path_player.sv
// Bench for led_path_player: random and directed requests against a
// path-list reference model.
module tb_led_path_player;

  localparam int unsigned S  = 4;
  localparam int unsigned EB = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] target;
  logic       target_ok;
  logic [9:0] ledr;
  logic       busy;
  logic       done;
  logic       error;

  int total;
  int bad;

  logic [9:0] exp_q[$];
  bit         exp_err;

  led_path_player #(.STEP_CYCLES(S), .ERR_BLINKS(EB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .target(target),
    .target_ok(target_ok), .ledr(ledr), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle LED list, straight from the path rules.
  task automatic build_exp(input int t, input bit ok);
    int d;
    int node;
    logic [9:0] mask;
    exp_q.delete();
    if (ok && t <= 6) begin
      d = $clog2(t + 2) - 1;
      mask = '0;
      for (int k = 0; k <= d; k++) begin
        node = ((t + 1) >> (d - k)) - 1;
        mask = mask | 10'(1 << (node + 1));
        repeat (S) exp_q.push_back(10'(1 << (node + 1)));
      end
      repeat (S) exp_q.push_back(mask);
      exp_err = 1'b0;
    end else begin
      repeat (EB) begin
        repeat (S) exp_q.push_back(10'h300);
        repeat (S) exp_q.push_back(10'h000);
      end
      exp_err = 1'b1;
    end
  endtask

  task automatic drive(input int t, input bit ok);
    start     = 1'b1;
    target    = 3'(t);
    target_ok = ok;
  endtask

  // Follows an accepted request to its done cycle; stray_at >= 0 pulses an ignored start.
  task automatic play(input int t, input bit ok, input int stray_at);
    build_exp(t, ok);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      if (i == stray_at) begin
        start = 1'b1; target = 3'd3; target_ok = 1'b1;
      end else begin
        start = 1'b0; target = 3'($urandom); target_ok = 1'($urandom);
      end
      check("ledr", 32'(ledr), 32'(exp_q[i]));
      check("busy", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      check("error_early", 32'(error), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    check("done_end", 32'(done), 32'd1);
    check("error_end", 32'(error), 32'(exp_err));
    check("busy_end", 32'(busy), 32'd0);
    check("ledr_end", 32'(ledr), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; target = 3'($urandom); target_ok = 1'($urandom);
      check("idle_ledr", 32'(ledr), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_error", 32'(error), 32'd0);
    end
  endtask

  initial begin
    int t;
    bit ok;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    target = 3'd0;
    target_ok = 1'b0;

    // Reset with random inputs, then release and stay idle.
    repeat (3) begin
      @(negedge clk);
      start = 1'($urandom); target = 3'($urandom); target_ok = 1'($urandom);
      check("rst_ledr", 32'(ledr), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    idle(3);

    // Directed paths and error sequences.
    drive(0, 1'b1); play(0, 1'b1, -1); idle(2);
    drive(5, 1'b1); play(5, 1'b1, -1); idle(1);
    drive(int'($urandom_range(0, 7)), 1'b0); play(0, 1'b0, -1); idle(1);
    drive(7, 1'b1); play(7, 1'b1, -1); idle(1);

    // Ignored mid-animation start, then back-to-back start on the done cycle.
    drive(6, 1'b1); play(6, 1'b1, 2);
    drive(1, 1'b1); play(1, 1'b1, -1); idle(2);

    // Asynchronous reset during WALK step 1.
    drive(6, 1'b1);
    repeat (6) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_ledr", 32'(ledr), 32'h008);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ledr", 32'(ledr), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    drive(2, 1'b1); play(2, 1'b1, -1); idle(1);

    // Randomized requests, sometimes chained on the done cycle.
    repeat (25) begin
      t  = int'($urandom_range(0, 7));
      ok = ($urandom_range(0, 3) != 0);
      drive(t, ok);
      play(t, ok, ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
